// File: rtl/stopwatch_pkg.sv
// Shared types and seven-segment helpers for the stopwatch display path.
// Segment vectors are {g,f,e,d,c,b,a} and active-low.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      S_LATCH = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         // codes 10..15 are not valid BCD; show a dash so the fault is visible
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD to active-low seven-segment decoder.
module seg_decoder
   import stopwatch_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/stopwatch_display_scan.sv
// Time-multiplexed common-anode display scanner with per-frame shadow capture.
// Optional leading-zero blanking is enabled with `define STOPWATCH_LZ_BLANK_EN.
module stopwatch_display_scan
   import stopwatch_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 500
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [4*NUM_DIGITS-1:0] digits_bcd,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   scan_state_e                 r_state;
   logic [IDX_W-1:0]            r_idx;
   logic [CNT_W-1:0]            r_cnt;
   logic [4*NUM_DIGITS-1:0]     r_shadow_bcd;
   logic [NUM_DIGITS-1:0]       r_shadow_dp;
   logic [6:0]                  r_seg;
   logic                        r_dp;
   logic [NUM_DIGITS-1:0]       r_an;
   logic                        r_frame_start;

   scan_state_e                 w_state_nxt;
   logic [IDX_W-1:0]            w_idx_nxt;
   logic [CNT_W-1:0]            w_cnt_nxt;
   logic [3:0]                  w_digit_arr [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]       w_lz_blank;
   logic [6:0]                  w_seg_dec;
   logic [6:0]                  w_seg_nxt;
   logic                        w_dp_nxt;
   logic [NUM_DIGITS-1:0]       w_an_nxt;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      assign w_digit_arr[g] = r_shadow_bcd[4*g +: 4];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_LATCH: begin
            w_state_nxt = S_BLANK;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
         end
         S_BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               w_state_nxt = S_DRIVE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_DRIVE: begin
            if (r_cnt == SCAN_LAST) begin
               w_cnt_nxt = '0;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = S_LATCH;
               end else begin
                  w_idx_nxt   = r_idx + IDX_W'(1);
                  w_state_nxt = S_BLANK;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_LATCH;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

`ifdef STOPWATCH_LZ_BLANK_EN
   // A digit is blanked while it and every digit above it read zero.
   always_comb begin
      logic v_zero;
      v_zero     = 1'b1;
      w_lz_blank = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         v_zero        = v_zero & (w_digit_arr[k] == 4'd0);
         w_lz_blank[k] = v_zero;
      end
   end
`else
   assign w_lz_blank = '0;
`endif

   seg_decoder u_seg_decoder (
      .i_bcd (w_digit_arr[w_idx_nxt]),
      .o_seg (w_seg_dec)
   );

   // Outputs are computed for the state being entered so they register in step with it.
   always_comb begin
      w_seg_nxt = SEG_OFF;
      w_dp_nxt  = 1'b1;
      w_an_nxt  = '1;
      if (w_state_nxt == S_DRIVE) begin
         w_dp_nxt = ~r_shadow_dp[w_idx_nxt];
         if (!w_lz_blank[w_idx_nxt]) begin
            w_an_nxt[w_idx_nxt] = 1'b0;
            w_seg_nxt           = w_seg_dec;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state       <= S_LATCH;
         r_idx         <= '0;
         r_cnt         <= '0;
         r_shadow_bcd  <= '0;
         r_shadow_dp   <= '0;
         r_seg         <= SEG_OFF;
         r_dp          <= 1'b1;
         r_an          <= '1;
         r_frame_start <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_idx         <= w_idx_nxt;
         r_cnt         <= w_cnt_nxt;
         r_seg         <= w_seg_nxt;
         r_dp          <= w_dp_nxt;
         r_an          <= w_an_nxt;
         r_frame_start <= (r_state == S_LATCH);
         if (r_state == S_LATCH) begin
            r_shadow_bcd <= digits_bcd;
            r_shadow_dp  <= dp_mask;
         end
      end
   end

   assign seg         = r_seg;
   assign dp          = r_dp;
   assign an          = r_an;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Scoreboard bench for stopwatch_display_scan (4 digits, 4-cycle drive, 2-cycle blank).
module tb_stopwatch_display_scan;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = SD + BC;
  localparam int FRAME = ND * SLOT + 1;

  // packed observation: {frame_start, an[3:0], seg[6:0], dp}
  localparam logic [12:0] RST_OUT = {1'b0, 4'hF, 7'h7F, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_bcd = 16'h0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] exp_q[$];
  int          p = 0;
  bit          started = 1'b0;
  logic [15:0] m_bcd = 16'h0000;
  logic [3:0]  m_dp = 4'b0000;

  always #5 clk = ~clk;

  stopwatch_display_scan #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .digits_bcd  (digits_bcd),
    .dp_mask     (dp_mask),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  task automatic check_eq(input string tag, input logic [12:0] act, input logic [12:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got fs/an/seg/dp=%b/%b/%b/%b expected %b/%b/%b/%b", tag,
               act[12], act[11:8], act[7:1], act[0], exp[12], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected outputs at frame position pos (0 = cycle right after the capture edge).
  function automatic logic [12:0] ref_out(input int pos);
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
    logic [3:0]  dig;
    logic [15:0] upper;
    logic        blank;
    int          k;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    dp_e  = 1'b1;
    if (pos < ND * SLOT && (pos % SLOT) >= BC) begin
      k     = pos / SLOT;
      upper = m_bcd >> (4 * k);
      dig   = upper[3:0];
      dp_e  = ~m_dp[k[1:0]];
`ifdef STOPWATCH_LZ_BLANK_EN
      blank = (k >= 1) && (upper == 16'h0000);
`else
      blank = 1'b0;
`endif
      if (!blank) begin
        an_e  = ~(4'b0001 << k);
        seg_e = ref_seg(dig);
      end
    end
    return {(pos == 0), an_e, seg_e, dp_e};
  endfunction

  // reference model: advances frame position on every clock edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        started = 1'b0;
        exp_q.push_back(RST_OUT);
      end else begin
        if (!started) begin
          started = 1'b1;
          p = 0;
        end else begin
          p = (p + 1) % FRAME;
        end
        if (p == 0) begin
          m_bcd = digits_bcd;
          m_dp  = dp_mask;
        end
        exp_q.push_back(ref_out(p));
      end
    end
  end

  // monitor: compare every cycle on the falling edge
  initial begin
    logic [12:0] exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        if (rst) exp = RST_OUT;
        check_eq($sformatf("scan p%0d", p), {frame_start, an, seg, dp}, exp);
      end
    end
  end

  task automatic wait_p(input int target);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clk);
      #2;
      if (started && p == target) return;
    end
    check_eq("wait_p timeout", 13'(p), 13'(target));
  endtask

  initial begin
    rst        = 1'b1;
    digits_bcd = 16'h1259;
    dp_mask    = 4'b0100;
    repeat (3) @(posedge clk);
    #1;
    check_eq("in_reset", {frame_start, an, seg, dp}, RST_OUT);
    #1;
    rst = 1'b0;

    // two full frames of 1259 with dp on digit 2
    wait_p(0);
    wait_p(FRAME - 1);
    wait_p(FRAME - 1);

    // tearing: inputs change during digit 1 drive, must not show until next frame
    digits_bcd = 16'h0000;
    dp_mask    = 4'b0000;
    wait_p(0);
    wait_p(BC + SLOT + 1);
    digits_bcd = 16'h1111;
    wait_p(FRAME - 1);
    wait_p(FRAME - 1);

    // invalid BCD shows a dash
    digits_bcd = 16'h00A0;
    wait_p(0);
    wait_p(FRAME - 1);

    // leading zeros (blanked only when the feature is built in)
    digits_bcd = 16'h0005;
    dp_mask    = 4'b0011;
    wait_p(0);
    wait_p(FRAME - 1);
    digits_bcd = 16'h0000;
    dp_mask    = 4'b0000;
    wait_p(0);
    wait_p(FRAME - 1);

    // random frames with mid-frame input churn
    for (int f = 0; f < 3; f++) begin
      digits_bcd = 16'($urandom_range(0, 65535));
      dp_mask    = 4'($urandom_range(0, 15));
      wait_p(0);
      wait_p($urandom_range(2, FRAME - 3));
      digits_bcd = 16'($urandom_range(0, 65535));
      dp_mask    = 4'($urandom_range(0, 15));
      wait_p(FRAME - 1);
    end

    // asynchronous reset in the middle of digit 2 drive
    digits_bcd = 16'h4321;
    dp_mask    = 4'b0100;
    wait_p(0);
    wait_p(2 * SLOT + BC + 1);
    rst = 1'b1;
    #1;
    check_eq("async_rst", {frame_start, an, seg, dp}, RST_OUT);
    @(posedge clk);
    #2;
    rst = 1'b0;
    wait_p(0);
    wait_p(FRAME - 1);

    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
